// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings and
// byte-lane helpers for the SRAM slave.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HW   = 3'b001;
  localparam logic [2:0] SZ_W    = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] byte_mask(
    input logic [2:0] size,
    input logic [1:0] lane
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (size == SZ_BYTE): m = 4'b0001 << lane;
      (size == SZ_HW):   m = 4'b0011 << lane;
      default:           m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_expand(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/ahbl_sram_ctrl_wbuf.sv
// ahbl_wbuf: one-entry posted write buffer
// with drain handshake and read forwarding.
module ahbl_wbuf
  import ahbl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch,
  input  logic [ADDR_WIDTH-1:0] latch_addr,
  input  logic [3:0]            latch_mask,
  input  logic                  load,
  input  logic [31:0]           load_data,
  output logic                  drain_req,
  input  logic                  drain_ack,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [3:0]            wb_mask,
  output logic [31:0]           wb_data,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  input  logic [31:0]           fwd_raw,
  output logic [31:0]           fwd_data
);

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [3:0]            pend_mask;
  logic                  hit;

  function automatic logic [31:0] merge(
    input logic [31:0] raw,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = m[b] ? wd[8*b +: 8]
                         : raw[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_mask   <= '0;
      wb_data   <= '0;
      pend_addr <= '0;
      pend_mask <= '0;
    end else begin
      if (latch) begin
        pend_addr <= latch_addr;
        pend_mask <= latch_mask;
      end
      // a load in the drain cycle keeps the new entry
      if (load) begin
        wb_valid <= 1'b1;
        wb_addr  <= pend_addr;
        wb_mask  <= pend_mask;
        wb_data  <= load_data &
                    lane_expand(pend_mask);
      end else if (drain_ack) begin
        wb_valid <= 1'b0;
      end
    end
  end

  assign drain_req = wb_valid;
  assign hit       = wb_valid &&
                     (wb_addr == fwd_addr);
  assign fwd_data  = merge(fwd_raw, wb_data,
                           hit ? wb_mask : 4'b0);

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// ahbl_sram_ctrl: AHB-Lite slave in front of a
// single-port synchronous SRAM macro.
module ahbl_sram_ctrl
  import ahbl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [3:0]            sram_wmask,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam int WCW = (WAIT_STATES > 0) ?
    $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WS_INIT =
    WCW'(WAIT_STATES);

  state_t                state_q, state_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  late_q, late_d;
  logic                  cap_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [31:0]           rdata_q;

  logic                  go, legal, mis, hi_ok;
  logic                  rd_acc, wr_acc, bad_acc;
  logic                  wr_done, conflict;
  logic                  rd_now, rd_late, rd_issue;
  logic                  drain_req, drain_ack;
  logic [ADDR_WIDTH-1:0] haddr_w;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [3:0]            wb_mask;
  logic [31:0]           wb_data, fwd_data;
  logic                  unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign haddr_w = HADDR[ADDR_WIDTH+1:2];
  assign hi_ok   = HADDR[31:ADDR_WIDTH+2] == '0;
  assign mis     =
    (HSIZE == SZ_HW && HADDR[0]) ||
    (HSIZE == SZ_W && HADDR[1:0] != 2'b00);
  assign legal   = (HSIZE <= SZ_W) && !mis && hi_ok;

  assign go      = HSEL & HTRANS[1] & HREADY &
                   hready_q;
  assign rd_acc  = go & legal & ~HWRITE;
  assign wr_acc  = go & legal & HWRITE;
  assign bad_acc = go & ~legal;

  assign wr_done  = (state_q == ST_WR) & hready_q;
  // the buffer must drain to make room for this write
  assign conflict = rd_acc & wr_done & drain_req;

  assign rd_now    = rd_acc & ~conflict & ~rst;
  assign rd_late   = (state_q == ST_RD) & late_q &
                     ~rst;
  assign rd_issue  = rd_now | rd_late;
  assign drain_ack = drain_req & ~rd_issue & ~rst;

  ahbl_wbuf #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .latch     (wr_acc),
    .latch_addr(haddr_w),
    .latch_mask(byte_mask(HSIZE, HADDR[1:0])),
    .load      (wr_done),
    .load_data (HWDATA),
    .drain_req (drain_req),
    .drain_ack (drain_ack),
    .wb_addr   (wb_addr),
    .wb_mask   (wb_mask),
    .wb_data   (wb_data),
    .fwd_addr  (rd_addr_q),
    .fwd_raw   (sram_rdata),
    .fwd_data  (fwd_data)
  );

  always_comb begin
    state_d  = state_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    wcnt_d   = wcnt_q;
    late_d   = late_q;
    unique case (1'b1)
      (state_q == ST_ERR1): begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      (state_q == ST_RD && !hready_q): begin
        // the conflict slot is spent before the waits
        if (late_q) begin
          late_d   = 1'b0;
          hready_d = (wcnt_q == '0);
        end else begin
          wcnt_d   = wcnt_q - WCW'(1);
          hready_d = (wcnt_q == WCW'(1));
        end
      end
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        wcnt_d   = '0;
        late_d   = 1'b0;
        if (bad_acc) begin
          state_d  = ST_ERR1;
          hready_d = 1'b0;
          hresp_d  = HRESP_ERROR;
        end else if (rd_acc) begin
          state_d  = ST_RD;
          wcnt_d   = WS_INIT;
          late_d   = conflict;
          hready_d = (WAIT_STATES == 0) &&
                     !conflict;
        end else if (wr_acc) begin
          state_d  = ST_WR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      wcnt_q    <= '0;
      late_q    <= 1'b0;
      cap_q     <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      wcnt_q   <= wcnt_d;
      late_q   <= late_d;
      cap_q    <= rd_issue;
      if (rd_acc)
        rd_addr_q <= haddr_w;
      if (cap_q)
        rdata_q <= fwd_data;
    end
  end

  assign HREADYOUT  = hready_q;
  assign HRESP      = hresp_q;
  assign HRDATA     = cap_q ? fwd_data : rdata_q;

  assign sram_cs    = rd_issue | drain_ack;
  assign sram_we    = drain_ack;
  assign sram_addr  = rd_now  ? haddr_w   :
                      rd_late ? rd_addr_q : wb_addr;
  assign sram_wmask = drain_ack ? wb_mask : 4'b0;
  assign sram_wdata = wb_data;

endmodule
